// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - drain state encoding, default sizes and the requantize helper
package sa_pkg;
  localparam int WIDTH_D = 19;
  localparam int DEPTH_D = 8;
  localparam int OUT_W_D = 8;
  localparam int SHW_D   = 5;
  localparam int TW      = WIDTH_D + 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_t;

  // Round half up, optional ReLU, then saturate into a signed OUT_W_D sample.
  function automatic logic [OUT_W_D-1:0] requant(input logic [WIDTH_D:0] x,
                                                 input logic [SHW_D-1:0] sh,
                                                 input logic relu);
    logic signed [TW-1:0] xe;
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] y;
    logic signed [TW-1:0] qmax;
    qmax = TW'((1 << (OUT_W_D - 1)) - 1);
    xe   = {x[WIDTH_D], x};
    t    = '0;
    if (sh == '0) begin
      y = xe;
    end else if (int'(sh) >= WIDTH_D + 1) begin
      y = {TW{x[WIDTH_D]}};
    end else begin
      t = xe + (TW'(1) << (sh - 1'b1));
      y = t >>> sh;
    end
    if (relu && (y < 0)) y = '0;
    if (y > qmax) y = qmax;
    else if (y < ~qmax) y = ~qmax;
    return y[OUT_W_D-1:0];
  endfunction
endpackage

// File: rtl/o_drain_fifo.sv
// rtl/o_drain_fifo.sv - two-entry fall-through FIFO carrying {data, last}
module o_drain_fifo #(
  parameter int DW = 21
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count
);
  logic [DW-1:0] mem [2];
  logic          wp;
  logic          rp;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rp];
endmodule

// File: rtl/o_buf_drain.sv
// rtl/o_buf_drain.sv - sweeps the output buffer, requantizes each entry and streams it out
module o_buf_drain
  import sa_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int OUT_W = OUT_W_D,
  parameter int SHW   = SHW_D
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SHW-1:0]           shift_i,
  input  logic                     relu_i,
  input  logic                     bias_en_i,
  input  logic [WIDTH-1:0]         bias_i,
  output logic [$clog2(DEPTH)-1:0] raddr_o,
  input  logic [WIDTH:0]           rdata_i,
  output logic                     cw_vo,
  output logic [WIDTH-1:0]         cdata_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [OUT_W-1:0]         m_data_o,
  output logic                     m_last_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  drain_state_t     state, state_n;
  logic [AW-1:0]    cnt, raddr_q;
  logic             inflight, inflight_last;
  logic [SHW-1:0]   shift_q;
  logic             relu_q, bias_en_q;
  logic [WIDTH-1:0] bias_q;
  logic [WIDTH+1:0] head;
  logic [1:0]       level;
  logic [2:0]       credit;
  logic             issue, pop;

  // credit counts queued plus in-flight entries, with this cycle's pop already freed
  assign m_valid_o = (level != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  assign credit    = {1'b0, level} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (credit < 3'd2);

  assign raddr_o  = issue ? cnt : raddr_q;
  assign cw_vo    = issue & bias_en_q;
  assign cdata_o  = cw_vo ? bias_q : '0;
  assign m_data_o = m_valid_o ? requant(head[WIDTH+1:1], shift_q, relu_q) : '0;
  assign m_last_o = m_valid_o & head[0];
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);

  o_drain_fifo #(.DW(WIDTH + 2)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (inflight),
    .wdata ({rdata_i, inflight_last}),
    .pop   (pop),
    .rdata (head),
    .count (level)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = RUN;
      RUN:     if (issue && (cnt == LAST_ADDR)) state_n = FLUSH;
      FLUSH:   if (credit == 3'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt           <= '0;
      raddr_q       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      bias_en_q     <= 1'b0;
      bias_q        <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (cnt == LAST_ADDR);
      if ((state == IDLE) && start_i) begin
        cnt       <= '0;
        shift_q   <= shift_i;
        relu_q    <= relu_i;
        bias_en_q <= bias_en_i;
        bias_q    <= bias_i;
      end else if (issue) begin
        raddr_q <= cnt;
        cnt     <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_o_buf_drain.sv
// tb/tb_o_buf_drain.sv - directed table-driven bench for o_buf_drain
module tb_o_buf_drain;
  localparam int W  = 19;
  localparam int D  = 8;
  localparam int OW = 8;
  localparam int SW = 5;
  localparam int AW = 3;
  localparam int RW = W + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          start_i = 1'b0;
  logic [SW-1:0] shift_i = '0;
  logic          relu_i = 1'b0;
  logic          bias_en_i = 1'b0;
  logic [W-1:0]  bias_i = '0;
  logic [AW-1:0] raddr_o;
  logic [W:0]    rdata_i;
  logic          cw_vo;
  logic [W-1:0]  cdata_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [OW-1:0] m_data_o;
  logic          m_last_o;
  logic          busy_o;
  logic          done_o;

  o_buf_drain dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .shift_i(shift_i),
    .relu_i(relu_i), .bias_en_i(bias_en_i), .bias_i(bias_i), .raddr_o(raddr_o),
    .rdata_i(rdata_i), .cw_vo(cw_vo), .cdata_o(cdata_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Registered-read buffer: same-cycle write returns the old value.
  logic [W:0] mem [D];
  logic [W:0] init_vals [D];
  logic       do_load = 1'b0;
  always @(posedge clk_i) begin
    if (do_load) begin
      for (int i = 0; i < D; i++) mem[i] <= init_vals[i];
    end else if (cw_vo) begin
      mem[raddr_o] <= {cdata_o[W-1], cdata_o};
    end
    rdata_i <= mem[raddr_o];
  end

  typedef struct {
    logic [SW-1:0] sh;
    logic          rl;
    int            exp [D];
  } vec_t;

  vec_t tbl [3];
  int   total = 0;
  int   bad = 0;
  int   bdata[$];
  int   blast[$];
  int   bcyc[$];
  int   rseq[$];
  int   done_cyc, issued, max_out, stall_bad, cdata_bad, busy0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem();
    int iv [D] = '{256, 24, -40, 5000, -5000, 8, 7, 0};
    for (int i = 0; i < D; i++) init_vals[i] = RW'(iv[i]);
    do_load = 1'b1;
    @(posedge clk_i); #1 do_load = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1,0,0,...
  task automatic run_drain(input logic [SW-1:0] sh, input logic rl, input logic be,
                           input int bias, input int mode, input int stop_beats,
                           input int restart_c);
    logic [OW-1:0] held;
    logic          held_v;
    logic          held_last;
    bdata.delete(); blast.delete(); bcyc.delete(); rseq.delete();
    done_cyc = -1; issued = 0; max_out = 0; stall_bad = 0; cdata_bad = 0; busy0 = 0;
    held = '0; held_v = 1'b0; held_last = 1'b0;
    shift_i = sh; relu_i = rl; bias_en_i = be; bias_i = W'(bias); start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      m_ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      start_i   = (c == restart_c);
      @(negedge clk_i);
      if (c == 0) busy0 = busy_o;
      if (held_v && (!m_valid_o || m_data_o != held || m_last_o != held_last)) stall_bad++;
      if (cw_vo) begin
        issued++;
        rseq.push_back(int'(raddr_o));
        if (cdata_o != W'(bias)) cdata_bad++;
      end
      if (m_valid_o && m_ready_i) begin
        bdata.push_back(int'($signed(m_data_o)));
        blast.push_back(int'(m_last_o));
        bcyc.push_back(c);
      end
      if (issued - bdata.size() > max_out) max_out = issued - bdata.size();
      held_v = m_valid_o && !m_ready_i;
      held = m_data_o;
      held_last = m_last_o;
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (stop_beats > 0 && bdata.size() >= stop_beats) break;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int exp [D]);
    check({tag, ":nbeats"}, bdata.size(), D);
    check({tag, ":busy"}, busy0, 1);
    for (int i = 0; i < D; i++) begin
      if (i < bdata.size()) begin
        check($sformatf("%s:beat%0d", tag, i), bdata[i], exp[i]);
        check($sformatf("%s:last%0d", tag, i), blast[i], (i == D - 1) ? 1 : 0);
      end
    end
    if (bdata.size() == D) check({tag, ":done_lat"}, done_cyc, bcyc[D-1] + 1);
    else check({tag, ":done_seen"}, done_cyc >= 0 ? 1 : 0, 1);
  endtask

  task automatic check_idle_after(input string tag);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check({tag, ":done_pulse"}, int'(done_o), 0);
    check({tag, ":idle"}, int'(busy_o), 0);
  endtask

  initial begin
    tbl[0].sh = 5'd4; tbl[0].rl = 1'b0; tbl[0].exp = '{16, 2, -2, 127, -128, 1, 0, 0};
    tbl[1].sh = 5'd3; tbl[1].rl = 1'b1; tbl[1].exp = '{32, 3, 0, 127, 0, 1, 1, 0};
    tbl[2].sh = 5'd0; tbl[2].rl = 1'b0; tbl[2].exp = '{127, 24, -40, 127, -128, 8, 7, 0};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst:valid", int'(m_valid_o), 0);
    check("rst:busy", int'(busy_o), 0);
    check("rst:done", int'(done_o), 0);
    check("rst:raddr", int'(raddr_o), 0);
    check("rst:cw", int'(cw_vo), 0);
    rst_i = 1'b1;
    load_mem();

    for (int v = 0; v < 3; v++) begin
      run_drain(tbl[v].sh, tbl[v].rl, 1'b0, 0, 0, 0, -1);
      check_beats($sformatf("vec%0d", v), tbl[v].exp);
      if (bdata.size() == D) check($sformatf("vec%0d:tput", v), bcyc[D-1] - bcyc[0], D - 1);
      check($sformatf("vec%0d:nocw", v), issued, 0);
      check_idle_after($sformatf("vec%0d", v));
    end

    // Stalling downstream; bias writes expose each read issue.
    run_drain(5'd4, 1'b0, 1'b1, 0, 1, 0, -1);
    check_beats("stall", tbl[0].exp);
    check("stall:held", stall_bad, 0);
    check("stall:max_out_le2", (max_out <= 2) ? 1 : 0, 1);
    check("stall:issues", issued, D);
    load_mem();

    // Bias write-back, then a second drain sees the bias everywhere.
    run_drain(5'd0, 1'b0, 1'b1, 100, 0, 0, -1);
    check_beats("bias1", tbl[2].exp);
    check("bias1:cw_count", issued, D);
    check("bias1:cdata", cdata_bad, 0);
    for (int i = 0; i < D; i++) begin
      if (i < rseq.size()) check($sformatf("bias1:waddr%0d", i), rseq[i], i);
    end
    begin
      int e100 [D] = '{100, 100, 100, 100, 100, 100, 100, 100};
      check_idle_after("bias1");
      run_drain(5'd0, 1'b0, 1'b0, 0, 0, 0, -1);
      check_beats("bias2", e100);
    end
    load_mem();

    // Reset after three beats abandons the sweep.
    run_drain(5'd4, 1'b0, 1'b0, 0, 0, 3, -1);
    rst_i = 1'b0;
    #1;
    check("mid_rst:valid", int'(m_valid_o), 0);
    check("mid_rst:busy", int'(busy_o), 0);
    check("mid_rst:raddr", int'(raddr_o), 0);
    check("mid_rst:data", int'(m_data_o), 0);
    check("mid_rst:last", int'(m_last_o), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;

    // Start pulsed while busy and again during DONE: both ignored.
    run_drain(5'd4, 1'b0, 1'b0, 0, 0, 0, 4);
    check_beats("restart", tbl[0].exp);
    start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    check("done_start:busy", int'(busy_o), 0);
    repeat (3) @(negedge clk_i);
    check("done_start:valid", int'(m_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
